// File: rtl/decoder_4_16_strobe_pkg.sv
// rtl/decoder_4_16_strobe_pkg.sv - shared types and constants for the strobe decoder
package decoder_pkg;

    localparam int CODE_W  = 5;
    localparam int OUT_W   = 16;
    localparam int ERR_BIT = 4;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] line_onehot(input logic [IDX_W-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/decoder_4_16_strobe_dwell_counter.sv
// rtl/decoder_4_16_strobe_dwell_counter.sv - loadable down-counter with zero flag
module dwell_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over load so an abort can never leave a stale count behind
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_4_16_strobe.sv
// rtl/decoder_4_16_strobe.sv - registered 4-to-16 decoder with handshake and timed one-hot strobe
module decoder_4_16_strobe
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              err
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_HG > 1) ? MAX_HG : 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;
    logic              cnt_clear, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              accept;

    assign in_ready = enable && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;

    dwell_counter #(
        .W(CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        err_d        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = HOLD_LOAD;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in[ERR_BIT]) begin
                        err_d = 1'b1;
                    end else begin
                        out_d        = line_onehot(in[IDX_W-1:0]);
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LOAD;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                // Abort outranks expiry so a disabled block always lands idle
                if (!enable) begin
                    out_d     = '0;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    out_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                        state_d      = GAP;
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    out_d     = '0;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                out_d     = '0;
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign out = out_q;
    assign err = err_q;

endmodule

// File: tb/tb_decoder_4_16_strobe.sv
// tb/tb_decoder_4_16_strobe.sv - self-checking bench for decoder_4_16_strobe
module tb_decoder_4_16_strobe;

    localparam int HA = 4;
    localparam int GA = 1;
    localparam int HB = 1;
    localparam int GB = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a, v_a, rdy_a, busy_a, err_a;
    logic [4:0]  in_a;
    logic [15:0] out_a;
    logic        en_b, v_b, rdy_b, busy_b, err_b;
    logic [4:0]  in_b;
    logic [15:0] out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_4_16_strobe #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .in_valid(v_a), .in(in_a),
        .in_ready(rdy_a), .out(out_a), .busy(busy_a), .err(err_a)
    );

    decoder_4_16_strobe #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .in_valid(v_b), .in(in_b),
        .in_ready(rdy_b), .out(out_b), .busy(busy_b), .err(err_b)
    );

    // Reference: a strobe is "age" edges old; lit while age < HOLD, busy while age < HOLD+GAP
    typedef struct {
        bit       active;
        int       age;
        bit [3:0] line;
        bit       err;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, int h, int g, logic en, logic v, logic [4:0] c);
        model_t n = m;
        n.err = 1'b0;
        if (m.active) begin
            if (!en) begin
                n.active = 1'b0;
            end else begin
                n.age = m.age + 1;
                if (n.age >= h + g) n.active = 1'b0;
            end
        end else if (en && v) begin
            if (c[4]) begin
                n.err = 1'b1;
            end else begin
                n.active = 1'b1;
                n.age    = 0;
                n.line   = c[3:0];
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] mout(model_t m, int h);
        logic [15:0] one = 16'h0001;
        return (m.active && m.age < h) ? (one << m.line) : 16'h0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mstep(ma, HA, GA, en_a, v_a, in_a);
            mb <= mstep(mb, HB, GB, en_b, v_b, in_b);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a.out",   32'(out_a),  32'(mout(ma, HA)));
        chk("a.err",   32'(err_a),  32'(ma.err));
        chk("a.busy",  32'(busy_a), 32'(ma.active));
        chk("a.ready", 32'(rdy_a),  32'(en_a && !ma.active));
        chk("b.out",   32'(out_b),  32'(mout(mb, HB)));
        chk("b.err",   32'(err_b),  32'(mb.err));
        chk("b.busy",  32'(busy_b), 32'(mb.active));
        chk("b.ready", 32'(rdy_b),  32'(en_b && !mb.active));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("rst.a.out",  32'(out_a),  32'h0);
        chk("rst.a.busy", 32'(busy_a), 32'h0);
        chk("rst.a.err",  32'(err_a),  32'h0);
        chk("rst.b.out",  32'(out_b),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        check_model();
    endtask

    typedef struct {
        logic        en;
        logic        v;
        logic [4:0]  code;
        logic [15:0] out;
        logic        err;
        logic        busy;
        logic        rdy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 5'd5,     16'h0020, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 5'd0,     16'h0020, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 5'd0,     16'h0020, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,     16'h0020, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,     16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'd0,     16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 5'b10000, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 5'd3,     16'h0008, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,     16'h0008, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,     16'h0008, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd0,     16'h0008, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 5'd0,     16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 5'd0,     16'h0000, 1'b0, 1'b0, 1'b1};

        en_a = 1'b1; v_a = 1'b0; in_a = 5'd0;
        en_b = 1'b1; v_b = 1'b0; in_b = 5'd0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("reset.out",  32'(out_a),  32'h0);
        chk("reset.err",  32'(err_a),  32'h0);
        chk("reset.busy", 32'(busy_a), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.ready", 32'(rdy_a), 32'h1);
        chk("reset.out2",  32'(out_a), 32'h0);
        check_model();
        @(negedge clk);

        // Table: normal strobe, out-of-range code, immediately following accept
        for (int i = 0; i < 13; i++) begin
            en_a = tbl[i].en; v_a = tbl[i].v; in_a = tbl[i].code;
            tick();
            chk($sformatf("tbl%0d.out", i),   32'(out_a),  32'(tbl[i].out));
            chk($sformatf("tbl%0d.err", i),   32'(err_a),  32'(tbl[i].err));
            chk($sformatf("tbl%0d.busy", i),  32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.ready", i), 32'(rdy_a),  32'(tbl[i].rdy));
        end

        // Valid held high: codes 0 then 15 accepted 6 edges apart
        v_a = 1'b1; in_a = 5'd0;
        tick();
        chk("held.first", 32'(out_a), 32'h0001);
        in_a = 5'd15;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("held.t%0d", i), 32'(out_a),
                32'((i <= 3) ? 16'h0001 : (i < 6) ? 16'h0000 : 16'h8000));
        end
        v_a = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Enable dropped during the second hold cycle
        v_a = 1'b1; in_a = 5'd7;
        tick();
        v_a = 1'b0;
        tick();
        chk("abort.pre", 32'(out_a), 32'h0080);
        en_a = 1'b0;
        tick();
        chk("abort.out",   32'(out_a),  32'h0);
        chk("abort.busy",  32'(busy_a), 32'h0);
        chk("abort.ready", 32'(rdy_a),  32'h0);
        v_a = 1'b1; in_a = 5'd2;
        tick();
        chk("abort.blocked", 32'(out_a), 32'h0);
        en_a = 1'b1; v_a = 1'b0;
        tick();
        chk("abort.nostale", 32'(out_a), 32'h0);
        chk("abort.ready2",  32'(rdy_a), 32'h1);

        // Reset mid-hold, then mid-gap
        v_a = 1'b1; in_a = 5'd9;
        tick();
        v_a = 1'b0;
        tick();
        chk("rsthold.pre", 32'(out_a), 32'h0200);
        pulse_rst();
        v_a = 1'b1; in_a = 5'd1;
        tick();
        v_a = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rstgap.pre", 32'(busy_a), 32'h1);
        pulse_rst();
        en_a = 1'b0; v_a = 1'b1; in_a = 5'd4;
        tick();
        chk("postrst.noen", 32'(out_a), 32'h0);
        en_a = 1'b1;
        tick();
        chk("postrst.acc", 32'(out_a), 32'h0010);
        v_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // HOLD=1, GAP=0 variant: back-to-back period of 2
        v_b = 1'b1; in_b = 5'd4;
        tick();
        chk("b2b.first", 32'(out_b), 32'h0010);
        in_b = 5'd6;
        tick();
        chk("b2b.gap",   32'(out_b), 32'h0);
        chk("b2b.ready", 32'(rdy_b), 32'h1);
        tick();
        chk("b2b.second", 32'(out_b), 32'h0040);
        v_b = 1'b1; in_b = 5'd8;
        tick();
        pulse_rst();
        v_b = 1'b0;
        tick();

        // Randomized traffic on both instances against the reference model
        for (int i = 0; i < 400; i++) begin
            en_a = ($urandom_range(0, 15) != 0);
            v_a  = $urandom_range(0, 1);
            in_a = 5'($urandom_range(0, 31));
            en_b = ($urandom_range(0, 15) != 0);
            v_b  = $urandom_range(0, 1);
            in_b = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0) begin
                pulse_rst();
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
